// File: rtl/spsram_arb_pkg.sv
// Shared constants for the two-requester SRAM arbiter: requester count, read latency
// and command encoding.
package spsram_arb_pkg;

    localparam int NREQ   = 2;
    localparam int RD_LAT = 2;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_e;

endpackage

// File: rtl/spsram_arb_rr.sv
// Two-way round-robin grant logic. The pointer names the favoured requester when both
// request at once and flips to the other requester after every accepted grant.
module spsram_arb_rr
    import spsram_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (rstn) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // A grant is only ever issued to a requesting master, so any grant is an acceptance.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/spsram_arb.sv
// Round-robin arbiter and sequencer for one single-port SRAM shared by two requesters.
// Define SPSRAM_ARB_STAT_EN to add the o_gnt_cnt saturating per-requester grant counters.
module spsram_arb
    import spsram_arb_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [1:0]           i_req,
    input  logic [1:0]           i_we,
    input  logic [2*BW_ADDR-1:0] i_addr,
    input  logic [2*BW_DATA-1:0] i_wdata,
    output logic [1:0]           o_gnt,
    output logic [1:0]           o_rvalid,
    output logic [BW_DATA-1:0]   o_rdata,
    output logic                 o_mem_cen,
    output logic                 o_mem_wen,
    output logic                 o_mem_oen,
    output logic [BW_ADDR-1:0]   o_mem_addr,
    output logic [BW_DATA-1:0]   o_mem_data,
    input  logic [BW_DATA-1:0]   i_mem_data
`ifdef SPSRAM_ARB_STAT_EN
    ,
    output logic [31:0]          o_gnt_cnt
`endif
);

    logic               accept;
    logic               sel;
    cmd_e               cmd_sel;
    logic [BW_ADDR-1:0] addr_sel;
    logic [BW_DATA-1:0] data_sel;
    logic               vld_p1, id_p1;
    logic               vld_p2, id_p2;

    spsram_arb_rr u_rr (
        .clk  (i_clk),
        .rstn (i_rstn),
        .req  (i_req),
        .gnt  (o_gnt)
    );

    assign accept   = |o_gnt;
    assign sel      = o_gnt[1];
    assign cmd_sel  = cmd_e'(sel ? i_we[1] : i_we[0]);
    assign addr_sel = sel ? i_addr[2*BW_ADDR-1:BW_ADDR]  : i_addr[BW_ADDR-1:0];
    assign data_sel = sel ? i_wdata[2*BW_DATA-1:BW_DATA] : i_wdata[BW_DATA-1:0];

    // Stage p0 -> p1: command register driving the SRAM; addr/data hold while idle.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_mem_cen  <= 1'b0;
            o_mem_wen  <= 1'b0;
            o_mem_oen  <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
        end else begin
            o_mem_cen <= accept;
            o_mem_wen <= accept && (cmd_sel == CMD_WR);
            o_mem_oen <= accept && (cmd_sel == CMD_RD);
            if (accept) begin
                o_mem_addr <= addr_sel;
                o_mem_data <= data_sel;
            end
        end
    end

    // Stage p1 -> p2: read tag follows the SRAM's own registered read, so p2 lines up
    // with valid data on i_mem_data.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_p1 <= 1'b0;
            id_p1  <= 1'b0;
            vld_p2 <= 1'b0;
            id_p2  <= 1'b0;
        end else begin
            vld_p1 <= accept && (cmd_sel == CMD_RD);
            id_p1  <= sel;
            vld_p2 <= vld_p1;
            id_p2  <= id_p1;
        end
    end

    assign o_rvalid = {vld_p2 & id_p2, vld_p2 & ~id_p2};
    assign o_rdata  = i_mem_data;

`ifdef SPSRAM_ARB_STAT_EN
    logic [15:0] cnt0, cnt1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (o_gnt[0]) cnt0 <= sat_inc(cnt0);
            if (o_gnt[1]) cnt1 <= sat_inc(cnt1);
        end
    end

    assign o_gnt_cnt = {cnt1, cnt0};
`endif

endmodule

// File: tb/tb_spsram_arb.sv
// Self-checking bench for spsram_arb: behavioural SRAM, reference memory and a read
// scoreboard keyed on the expected return cycle.
module tb_spsram_arb;
    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;

    logic                 i_clk = 1'b0;
    logic                 i_rstn;
    logic [1:0]           i_req, i_we;
    logic [2*BW_ADDR-1:0] i_addr;
    logic [2*BW_DATA-1:0] i_wdata;
    logic [1:0]           o_gnt, o_rvalid;
    logic [BW_DATA-1:0]   o_rdata;
    logic                 o_mem_cen, o_mem_wen, o_mem_oen;
    logic [BW_ADDR-1:0]   o_mem_addr;
    logic [BW_DATA-1:0]   o_mem_data;
    logic [BW_DATA-1:0]   i_mem_data;
`ifdef SPSRAM_ARB_STAT_EN
    logic [31:0]          o_gnt_cnt;
`endif

    spsram_arb #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_gnt      (o_gnt),
        .o_rvalid   (o_rvalid),
        .o_rdata    (o_rdata),
        .o_mem_cen  (o_mem_cen),
        .o_mem_wen  (o_mem_wen),
        .o_mem_oen  (o_mem_oen),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .i_mem_data (i_mem_data)
`ifdef SPSRAM_ARB_STAT_EN
        ,
        .o_gnt_cnt  (o_gnt_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Behavioural single-port SRAM with registered read data.
    logic [BW_DATA-1:0] sram [32];
    initial i_mem_data = '0;
    always @(posedge i_clk) begin
        if (o_mem_cen && o_mem_wen) sram[o_mem_addr] <= o_mem_data;
        if (o_mem_cen && o_mem_oen) i_mem_data <= sram[o_mem_addr];
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic               id;
        logic [BW_DATA-1:0] data;
        int                 due;
    } exp_t;
    exp_t sb[$];

    logic [BW_DATA-1:0] ref_mem [32];
    logic               e_cen, e_wen, e_oen;
    logic [BW_ADDR-1:0] e_addr;
    logic [BW_DATA-1:0] e_data;

    // Read-return monitor.
    always @(negedge i_clk) begin
        if (o_rvalid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("rvalid_spurious", {62'd0, o_rvalid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_id", {62'd0, o_rvalid}, e.id ? 64'd2 : 64'd1);
                chk("rdata", {32'd0, o_rdata}, {32'd0, e.data});
                chk("rd_latency", 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("rvalid_missing", 64'd0, 64'd1);
            void'(sb.pop_front());
        end
    end

    task automatic chk_cmd();
        chk("mem_cen", {63'd0, o_mem_cen}, {63'd0, e_cen});
        chk("mem_wen", {63'd0, o_mem_wen}, {63'd0, e_wen});
        chk("mem_oen", {63'd0, o_mem_oen}, {63'd0, e_oen});
        chk("mem_addr", {59'd0, o_mem_addr}, {59'd0, e_addr});
        chk("mem_data", {32'd0, o_mem_data}, {32'd0, e_data});
    endtask

    // One cycle: check registered command, drive inputs, check grant, update model.
    task automatic step(input logic [1:0] req, input logic [1:0] we,
                        input logic [BW_ADDR-1:0] a0, input logic [BW_ADDR-1:0] a1,
                        input logic [BW_DATA-1:0] d0, input logic [BW_DATA-1:0] d1,
                        input logic [1:0] eg);
        logic k;
        logic [BW_ADDR-1:0] a;
        logic [BW_DATA-1:0] d;
        @(negedge i_clk);
        chk_cmd();
        i_req   = req;
        i_we    = we;
        i_addr  = {a1, a0};
        i_wdata = {d1, d0};
        #1;
        chk("gnt", {62'd0, o_gnt}, {62'd0, eg});
        if (eg != 2'b00) begin
            k = eg[1];
            a = k ? a1 : a0;
            d = k ? d1 : d0;
            e_cen = 1'b1;
            e_wen = we[k];
            e_oen = ~we[k];
            e_addr = a;
            e_data = d;
            if (we[k]) ref_mem[a] = d;
            else sb.push_back('{id: k, data: ref_mem[a], due: cyc + 2});
        end else begin
            e_cen = 1'b0;
            e_wen = 1'b0;
            e_oen = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (i > 0) begin
                chk_cmd();
                chk("rst_rvalid", {62'd0, o_rvalid}, 64'd0);
            end
            i_rstn = 1'b0;
            i_req  = 2'b11;
            i_we   = 2'b00;
            #1;
            chk("rst_gnt", {62'd0, o_gnt}, 64'd0);
            sb.delete();
            e_cen = 1'b0; e_wen = 1'b0; e_oen = 1'b0; e_addr = '0; e_data = '0;
        end
        @(negedge i_clk);
        chk_cmd();
        chk("rst_rvalid", {62'd0, o_rvalid}, 64'd0);
        i_req  = 2'b00;
        i_rstn = 1'b1;
    endtask

    typedef struct {
        logic [1:0]         req;
        logic [1:0]         we;
        logic [BW_ADDR-1:0] a0, a1;
        logic [BW_DATA-1:0] d0, d1;
        logic [1:0]         eg;
    } vec_t;
    vec_t tbl[$];

    initial begin
        i_rstn = 1'b0; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
        e_cen = 1'b0; e_wen = 1'b0; e_oen = 1'b0; e_addr = '0; e_data = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        // Contention: req0 writes addr 3, req1 reads addr 3; alternation from req0.
        for (int n = 0; n < 8; n++)
            tbl.push_back('{req: 2'b11, we: 2'b01, a0: 5'd3, a1: 5'd3,
                            d0: 32'hA5A5_0000 + 32'(n), d1: 32'h0,
                            eg: (n % 2 == 0) ? 2'b01 : 2'b10});
        // Ordering in both directions through address 7.
        tbl.push_back('{req: 2'b10, we: 2'b10, a0: 5'd0, a1: 5'd7, d0: 32'h0, d1: 32'hDEAD_BEEF, eg: 2'b10});
        tbl.push_back('{req: 2'b01, we: 2'b00, a0: 5'd7, a1: 5'd0, d0: 32'h0, d1: 32'h0, eg: 2'b01});
        tbl.push_back('{req: 2'b01, we: 2'b01, a0: 5'd7, a1: 5'd0, d0: 32'h1234_5678, d1: 32'h0, eg: 2'b01});
        tbl.push_back('{req: 2'b10, we: 2'b00, a0: 5'd0, a1: 5'd7, d0: 32'h0, d1: 32'h0, eg: 2'b10});

        do_reset(4);

        for (int i = 0; i < 32; i++) step(2'b01, 2'b01, 5'(i), '0, 32'(i), '0, 2'b01);
        for (int i = 0; i < 32; i++) step(2'b01, 2'b00, 5'(i), '0, '0, '0, 2'b01);
        idle(3);

        do_reset(2);
        foreach (tbl[i]) step(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].eg);
        idle(3);

        // Reset right after a read grant: no return, pointer back to requester 0.
        step(2'b01, 2'b00, 5'd5, '0, '0, '0, 2'b01);
        do_reset(1);
        idle(3);
        step(2'b11, 2'b00, 5'd1, 5'd2, '0, '0, 2'b01);
        step(2'b11, 2'b00, 5'd1, 5'd2, '0, '0, 2'b10);
        idle(3);

`ifdef SPSRAM_ARB_STAT_EN
        do_reset(2);
        for (int i = 0; i < 10; i++) step(2'b01, 2'b01, 5'(i), '0, 32'(i), '0, 2'b01);
        for (int i = 0; i < 6; i++)  step(2'b10, 2'b10, '0, 5'(i), '0, 32'(i), 2'b10);
        @(negedge i_clk);
        chk("gnt_cnt", {32'd0, o_gnt_cnt}, {32'd0, 16'd6, 16'd10});
`endif

        idle(2);
        if (sb.size() != 0) chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spsram_arb.md
Name: spsram_arb

Overview:
Two-requester round-robin arbiter and sequencer in front of one spsram instance (BW_DATA x 2^BW_ADDR).
- Accepts at most one read or write command per cycle.
- Drives registered SRAM controls and returns read data to the originating requester with fixed latency.
- Sits between two bus masters (e.g. DMA and CPU port) and the shared single-port memory.

Parameters:
BW_DATA, 32, data width of the SRAM and requester data buses
BW_ADDR, 5, address width of the SRAM (depth 2^BW_ADDR)

Ports:
i_clk  input  1  clock, all logic on posedge
i_rstn  input  1  synchronous active-low reset
i_req  input  2  per-requester command request, held until granted
i_we  input  2  per-requester command type: 1 write, 0 read
i_addr  input  2*BW_ADDR  per-requester address; requester k uses bits [k*BW_ADDR +: BW_ADDR]
i_wdata  input  2*BW_DATA  per-requester write data; same packing as i_addr
o_gnt  output  2  one-hot grant, combinational, valid in the accepting cycle
o_rvalid  output  2  one-hot read-data-valid
o_rdata  output  BW_DATA  read data, shared, qualified by o_rvalid
o_mem_cen  output  1  SRAM chip enable (registered)
o_mem_wen  output  1  SRAM write enable (registered)
o_mem_oen  output  1  SRAM output enable (registered)
o_mem_addr  output  BW_ADDR  SRAM address (registered)
o_mem_data  output  BW_DATA  SRAM write data (registered)
i_mem_data  input  BW_DATA  SRAM read data

Behaviour:
- Reset: i_rstn sampled low at posedge clears every register. Results: o_mem_cen/wen/oen=0, o_mem_addr=0, o_mem_data=0, o_rvalid=0, priority pointer=0 (requester 0 favoured), read pipeline empty. o_gnt=0 while i_rstn=0.
- Arbitration (combinational):
  - one request -> grant it.
  - both requesting -> grant the one indicated by the pointer.
  - no request -> o_gnt=0.
- Acceptance at posedge E0 when i_req[k]&o_gnt[k]. The requester must deassert or change its command in the following cycle.
- Pointer: after an accepted grant to k, pointer = ~k. Unchanged when idle.
- Command stage, registered at E0: o_mem_cen=1, o_mem_wen=i_we[k], o_mem_oen=~i_we[k], addr/data from requester k. With no acceptance: cen=wen=oen=0; addr/data hold their previous value.
- SRAM executes at E1. It returns registered read data valid after E1.
- Read return: 2-stage tag pipeline.
  - Stage 1 (valid, id) is loaded at E0 for reads.
  - Stage 2 is loaded at E1.
  - o_rvalid[id] = stage2 valid; o_rdata = i_mem_data (pass-through).
  - Read latency = 2 cycles from accept edge to o_rvalid cycle.
  - Writes produce no o_rvalid.
- Throughput: one command per cycle, back-to-back allowed. Reads and writes are executed strictly in grant order. A read granted after a write to the same address returns the new data, from either requester.
- Simultaneous events: both request every cycle -> grants alternate 0,1,0,1...
- Reset mid-operation: the pipeline is flushed. In-flight reads never assert o_rvalid; pending requests must be re-presented.

Optional Feature:
SPSRAM_ARB_STAT_EN
- Defined: adds output o_gnt_cnt (2*16 bits). Two saturating 16-bit grant counters, one per requester, each incremented on its accepted grant. Cleared by reset; hold at 16'hFFFF.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds: requester count NREQ=2, read latency constant RD_LAT=2, and command encoding constants CMD_RD=0, CMD_WR=1.
- One natural sub-module: spsram_arb_rr, the 2-way round-robin grant logic plus pointer register.
- Top level instantiates spsram_arb_rr plus the command and tag pipeline registers.

Test Plan:
- Reset: hold i_rstn=0 for 4 cycles with i_req=2'b11 -> o_gnt=0, o_mem_cen=0, o_rvalid=0 throughout.
- Single requester: requester 0 writes addr i data i for i=0..31, then reads 0..31 -> o_rvalid[0] 2 cycles after each read grant, o_rdata=i, o_rvalid[1] never set.
- Contention: both request every cycle; req0 writes 0xA5A5_0000+n, req1 reads addr 3 -> grants alternate starting with req0. The read returns the value most recently written to addr 3 before its grant.
- Ordering: req1 writes 0xDEAD_BEEF to addr 7; next cycle req0 reads addr 7 -> o_rvalid[0] with o_rdata=0xDEAD_BEEF.
- Reset mid-read: grant read to addr 5, assert i_rstn=0 next edge -> no o_rvalid; pointer returns to 0.
- SPSRAM_ARB_STAT_EN: 10 grants req0, 6 grants req1 -> o_gnt_cnt = {16'd6, 16'd10}.
